// File: rtl/la_spram_req_pkg.sv
// Shared constants for the single-port RAM request adapter.
// The RAM read latency and the smallest legal response-buffer depth live here.
package la_spram_req_pkg;

  localparam int unsigned RD_LATENCY = 1;
  localparam int unsigned MIN_DEPTH  = 2;

endpackage

// File: rtl/la_spram_req_if.sv
// Request/response handshake bundle between a client and la_spram_req.
// The master drives requests and consumes read responses.
interface la_spram_req_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 10
);

  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wmask;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wmask, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wmask, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/la_spram_rspfifo.sv
// Read-response FIFO of DEPTH entries. DEPTH need not be a power of two,
// so both pointers wrap explicitly from DEPTH-1 back to zero.
module la_spram_rspfifo
  import la_spram_req_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 3
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int unsigned PW = (DEPTH > MIN_DEPTH) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DW-1:0] store [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] fill;
  logic [CW-1:0] fill_nxt;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    fill_nxt = fill;
    case ({push, pop})
      2'b10:   fill_nxt = fill + CW'(1);
      2'b01:   fill_nxt = fill - CW'(1);
      default: fill_nxt = fill;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      fill <= fill_nxt;
    end
  end

  // Storage needs no reset: fill gates visibility of every entry.
  always_ff @(posedge clk) begin
    if (push) store[wr_ptr] <= din;
  end

  assign dout  = store[rd_ptr];
  assign empty = (fill == '0);
  assign full  = (fill == FULL_CNT);

endmodule

// File: rtl/la_spram_req.sv
// Valid/ready front end for a single-port RAM with 1-cycle read latency.
// Reads are only accepted while a buffer slot is guaranteed for their data.
module la_spram_req
  import la_spram_req_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 10,
  parameter int unsigned DEPTH = 3
) (
  input  logic          clk,
  input  logic          nreset,
  la_spram_req_if.slave bus,
  output logic          mem_ce,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wmask,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(DEPTH);

  logic [CW-1:0]         count;
  logic [CW-1:0]         count_nxt;
  logic [RD_LATENCY-1:0] inflight;
  logic                  accept;
  logic                  rd_accept;
  logic                  pop;
  logic                  fifo_push;
  logic                  fifo_full;
  logic                  fifo_empty;

  // Ready ignores rsp_ready, so a pop never combinationally enables an accept.
  assign bus.req_ready = nreset & (count < MAX_CNT);
  assign accept        = bus.req_valid & bus.req_ready;
  assign rd_accept     = accept & ~bus.req_we;

  assign mem_ce    = accept;
  assign mem_we    = accept & bus.req_we;
  assign mem_addr  = bus.req_addr;
  assign mem_wmask = accept ? bus.req_wmask : '0;
  assign mem_din   = bus.req_wdata;

  assign fifo_push     = inflight[RD_LATENCY-1];
  assign pop           = bus.rsp_valid & bus.rsp_ready;
  assign bus.rsp_valid = ~fifo_empty;

  // count covers reads in flight and reads buffered, hence bounds the FIFO.
  always_comb begin
    count_nxt = count;
    case ({rd_accept, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      count    <= '0;
      inflight <= '0;
    end else begin
      count       <= count_nxt;
      inflight[0] <= rd_accept;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        inflight[i] <= inflight[i-1];
      end
    end
  end

  la_spram_rspfifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_rspfifo (
    .clk    (clk),
    .nreset (nreset),
    .push   (fifo_push),
    .din    (mem_dout),
    .pop    (pop),
    .dout   (bus.rsp_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  a_no_overflow : assert property (@(posedge clk) disable iff (!nreset)
    !(fifo_push && fifo_full && !pop));

endmodule

// File: tb/tb_la_spram_req.sv
// Scoreboard bench for la_spram_req with a behavioural 1-cycle RAM.
// Expected read data comes from a shadow memory updated at request acceptance.
module tb_la_spram_req;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 10;
  localparam int unsigned DEPTH = 3;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          nreset;
  logic          mem_ce, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wmask, mem_din, mem_dout;

  logic [DW-1:0] ram     [1024];
  logic [DW-1:0] ref_mem [1024];
  exp_t          exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int accepts = 0;
  int pops = 0;
  logic [DW-1:0] last_pop;
  logic          hold = 1'b0;
  logic [DW-1:0] held_data;

  la_spram_req_if #(.DW(DW), .AW(AW)) bus ();

  la_spram_req #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .bus       (bus),
    .mem_ce    (mem_ce),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wmask (mem_wmask),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_we) ram[mem_addr] <= (ram[mem_addr] & ~mem_wmask) | (mem_din & mem_wmask);
      else        mem_dout <= ram[mem_addr];
    end
  end

  function automatic void chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: compares DUT outputs with the queue-based model every cycle.
  always @(negedge clk) begin
    logic exp_ready;
    logic exp_valid;
    if (!nreset) begin
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_mem_ce", 32'(mem_ce), 32'd0);
      exp_q.delete();
      hold = 1'b0;
    end else begin
      exp_ready = (exp_q.size() < DEPTH);
      exp_valid = (exp_q.size() > 0) && (exp_q[0].cyc + 2 <= cyc);
      chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_valid));
      chk("mem_ce", 32'(mem_ce), 32'(bus.req_valid && exp_ready));
      if (!(bus.req_valid && exp_ready)) chk("idle_wmask", mem_wmask, '0);
      if (bus.rsp_valid && hold) chk("rdata_stable", bus.rsp_rdata, held_data);
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          chk("rsp_rdata", bus.rsp_rdata, exp_q[0].data);
          void'(exp_q.pop_front());
        end
        last_pop = bus.rsp_rdata;
        pops++;
      end
      hold      = bus.rsp_valid && !bus.rsp_ready;
      held_data = bus.rsp_rdata;
      if (bus.req_valid && bus.req_ready) begin
        accepts++;
        if (bus.req_we) begin
          ref_mem[bus.req_addr] = (ref_mem[bus.req_addr] & ~bus.req_wmask) |
                                  (bus.req_wdata & bus.req_wmask);
        end else begin
          exp_q.push_back('{data: ref_mem[bus.req_addr], cyc: cyc});
        end
      end
    end
  end

  task automatic idle();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wmask = '0;
    bus.req_wdata = '0;
  endtask

  task automatic do_req(input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] mask, input logic [DW-1:0] data);
    logic got = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wmask = mask;
    bus.req_wdata = data;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = bus.req_ready;
      @(posedge clk);
      #1;
    end
    if (!got) chk("req_timeout", 32'd0, 32'd1);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 50 && (exp_q.size() != 0 || bus.rsp_valid); i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int c0;
    int a0;
    int p0;
    for (int i = 0; i < 1024; i++) begin
      ram[i]     = '0;
      ref_mem[i] = '0;
    end
    nreset = 1'b0;
    idle();
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    nreset = 1'b1;

    do_req(1'b1, 10'd5, 32'hFFFF_FFFF, 32'hDEAD_BEEF);
    do_req(1'b0, 10'd5, '0, '0);
    idle();
    drain();
    chk("read_full_write", last_pop, 32'hDEAD_BEEF);

    do_req(1'b1, 10'd5, 32'h0000_FFFF, 32'h1234_5678);
    do_req(1'b0, 10'd5, '0, '0);
    idle();
    drain();
    chk("read_masked_write", last_pop, 32'hDEAD_5678);

    for (int i = 0; i < 8; i++) begin
      if (i != 5) do_req(1'b1, 10'(i), 32'hFFFF_FFFF, $urandom);
    end
    idle();
    c0 = cyc;
    a0 = accepts;
    for (int i = 0; i < 8; i++) do_req(1'b0, 10'(i), '0, '0);
    idle();
    chk("b2b_accepts", 32'(accepts - a0), 32'd8);
    chk("b2b_cycles", 32'(cyc - c0), 32'd8);
    drain();

    bus.rsp_ready = 1'b0;
    a0 = accepts;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 10'd5;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    idle();
    chk("bp_accepts", 32'(accepts - a0), 32'd3);
    chk("bp_ready_low", 32'(bus.req_ready), 32'd0);
    p0 = pops;
    drain();
    chk("bp_pops", 32'(pops - p0), 32'd3);
    chk("bp_ready_back", 32'(bus.req_ready), 32'd1);

    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) do_req(1'b0, 10'(i), '0, '0);
    idle();
    nreset = 1'b0;
    #1;
    chk("async_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("async_req_ready", 32'(bus.req_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    nreset = 1'b1;
    bus.rsp_ready = 1'b1;
    p0 = pops;
    repeat (10) @(posedge clk);
    #1;
    chk("no_stale_rsp", 32'(pops - p0), 32'd0);

    for (int i = 0; i < 10000; i++) begin
      bus.req_valid = ($urandom_range(0, 99) < 60);
      bus.req_we    = ($urandom_range(0, 99) < 35);
      bus.req_addr  = 10'($urandom_range(0, 15));
      bus.req_wmask = $urandom;
      bus.req_wdata = $urandom;
      bus.rsp_ready = ($urandom_range(0, 99) < 55);
      @(posedge clk);
      #1;
    end
    idle();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/la_spram_req.md
LA_SPRAM_REQ -- requirements
Module: la_spram_req

Interface
REQ-001 Parameter DW, default 32, data width passed through to the RAM.
REQ-002 Parameter AW, default 10, address width passed through to the RAM.
REQ-003 Parameter DEPTH, default 3, read-response buffer entries; legal minimum 2.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset: ports clk and nreset.
REQ-005 clk  input  1  sole clock; all state rises on posedge.
REQ-006 nreset  input  1  asynchronous active-low reset.
REQ-007 req_valid  input  1  request present.
REQ-008 req_ready  output  1  request accepted when high with req_valid.
REQ-009 req_we  input  1  1 = write, 0 = read.
REQ-010 req_addr  input  AW  word address.
REQ-011 req_wmask  input  DW  per-bit write mask.
REQ-012 req_wdata  input  DW  write data.
REQ-013 rsp_valid  output  1  read data present.
REQ-014 rsp_ready  input  1  consumer takes read data.
REQ-015 rsp_rdata  output  DW  read data.
REQ-016 mem_ce, mem_we  output  1 each  to RAM ce/we.
REQ-017 mem_addr  output  AW; mem_wmask, mem_din  output  DW; mem_dout  input  DW  RAM port (1-cycle read latency).

Function
REQ-018 Accept = req_valid & req_ready; in the accept cycle mem_ce=1, mem_we=req_we, mem_addr/mem_wmask/mem_din = request fields (combinational pass-through); otherwise mem_ce=0, mem_we=0, mem_wmask=0.
REQ-019 Occupancy count = in-flight reads + buffered responses, range 0..DEPTH, width clog2(DEPTH+1).
REQ-020 req_ready SHALL be 1 iff count < DEPTH and nreset high; it SHALL NOT depend on rsp_ready, req_valid or req_we.
REQ-021 An accepted write produces no response and does not change count.
REQ-022 An accepted read in cycle N sets the in-flight flag; mem_dout is written into the buffer at the clk edge ending cycle N+1; rsp_valid is 1 from cycle N+2 at the earliest (latency 2).
REQ-023 Buffer is a FIFO of DEPTH entries; read/write pointers wrap DEPTH-1 -> 0 (DEPTH need not be a power of two).
REQ-024 rsp_valid = buffer non-empty; rsp_rdata = head entry, registered and stable while rsp_valid & !rsp_ready.
REQ-025 Pop on rsp_valid & rsp_ready; count decrements by 1.
REQ-026 Simultaneous read-accept and pop in one cycle: count unchanged; simultaneous capture and pop on the same buffer: both take effect, order-preserving.
REQ-027 Buffer overflow SHALL be impossible by construction (count bound); responses SHALL leave in request order.
REQ-028 With DEPTH>=3 and rsp_ready held 1, back-to-back reads SHALL sustain one accept per cycle.

Reset
REQ-029 nreset low SHALL immediately clear count, in-flight flag, pointers and rsp_valid, and force req_ready=0 and mem_ce=0.
REQ-030 Reset mid-operation discards in-flight and buffered reads; no response is produced for them after release.
REQ-031 The first accept is possible in the first clk cycle after nreset rises.

Structure
REQ-032 Read latency (1) and minimum DEPTH (2) SHALL be constants in the shared lambda package; no typedefs needed.
REQ-033 The response buffer SHALL be one sub-module, la_spram_rspfifo (DW, DEPTH parameters, push/pop/full/empty).
REQ-034 The block SHALL connect to la_spram with no glue logic.

Verification (DW=32, AW=10, DEPTH=3, behavioural 1-cycle RAM)
REQ-035 Write 0xDEADBEEF to addr 5 with mask 0xFFFFFFFF, then read addr 5 -> rsp_rdata=0xDEADBEEF at 2 cycles after read accept.
REQ-036 Write mask 0x0000FFFF with data 0x12345678 over 0xDEADBEEF -> read returns 0xDEAD5678.
REQ-037 Read addrs 0..7 back-to-back with rsp_ready=1 -> 8 accepts in 8 cycles, responses in order 2 cycles later.
REQ-038 rsp_ready=0, issue reads -> exactly 3 accepted, req_ready=0 afterwards, rsp_rdata stable; release -> 3 ordered pops, ready returns.
REQ-039 Assert nreset low with 2 buffered and 1 in-flight read -> rsp_valid=0 immediately; after release no stale responses appear.
REQ-040 Random valid/ready mix, 10k cycles -> scoreboard matches every read and count never exceeds 3.
